coef_reader: RTL and testbench

COEF_READER -- requirements
Module: coef_reader

---
 rtl/coef_reader_pkg.sv | 11 +
 rtl/coef_reader_if.sv | 26 ++
 rtl/coef_reader_skid.sv | 45 ++++
 rtl/coef_reader.sv | 90 +++++++++
 tb/tb_coef_reader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/coef_reader_pkg.sv
// Shared defaults and FSM encoding for the coefficient column reader.
package coef_reader_pkg;
  localparam int DEF_CW   = 16;
  localparam int DEF_COLS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/coef_reader_if.sv
// Buffer-read and column-stream signals of coef_reader; master is the reader side.
interface coef_reader_if
  import coef_reader_pkg::*;
#(
  parameter int CW = DEF_CW
);
  logic            notify;
  logic [3:0]      rd_addr;
  logic [8*CW-1:0] rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [8*CW-1:0] out_data;
  logic [2:0]      out_col;
  logic            out_last;
  logic            busy;
  logic            ovf;

  modport master (
    input  notify, rd_data, out_ready,
    output rd_addr, out_valid, out_data, out_col, out_last, busy, ovf
  );
  modport slave (
    output notify, rd_data, out_ready,
    input  rd_addr, out_valid, out_data, out_col, out_last, busy, ovf
  );
endinterface

// File: rtl/coef_reader_skid.sv
// Two-entry FIFO holding {last, col, data} between the buffer read and the IDCT.
module coef_skid
  import coef_reader_pkg::*;
#(
  parameter int W = 8*DEF_CW + 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic [1:0]   cnt;
  logic         do_push, do_pop;

  // A push into a full FIFO is only accepted when the head leaves the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);
endmodule

// File: rtl/coef_reader.sv
// Reads one block of coefficient columns after each page flip and streams them to the IDCT.
module coef_reader
  import coef_reader_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int CW   = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  coef_reader_if.master bus
);
  localparam int         W        = 8*CW + 4;
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  state_t       state;
  logic         pending;
  logic         infl, infl_last;
  logic [2:0]   col;
  logic [3:0]   rd_addr_q;
  logic         ovf_q;
  logic         push, pop, full, empty, issue;
  logic [1:0]   occ;
  logic [2:0]   occ_eff;
  logic [W-1:0] din, dout;

  assign pop  = ~empty & bus.out_ready;
  assign push = infl;
  assign occ  = full ? 2'd2 : (empty ? 2'd0 : 2'd1);

  // Credit counts the slot freed by this cycle's pop so a ready sink gets one column per cycle.
  assign occ_eff = 3'(occ) - 3'(pop) + 3'(infl);
  assign issue   = (state == READ) && (occ_eff < 3'd2);

  // rd_addr still holds the in-flight column when its data arrives.
  assign din = {infl_last, rd_addr_q[2:0], bus.rd_data};

  coef_skid #(.W(W)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      col       <= 3'd0;
      rd_addr_q <= 4'd0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      infl      <= issue;
      infl_last <= issue && (col == LAST_COL);
      if (issue) begin
        rd_addr_q <= {1'b0, col};
        col       <= col + 3'd1;
      end
      if (bus.notify && (pending || state != IDLE)) ovf_q <= 1'b1;
      case (state)
        // A notify seen in IDLE is consumed at once; a second one in the same cycle stays pending.
        IDLE: if (pending || bus.notify) begin
          state   <= READ;
          col     <= 3'd0;
          pending <= pending && bus.notify;
        end
        READ: begin
          pending <= pending | bus.notify;
          if (issue && col == LAST_COL) state <= DRAIN;
        end
        DRAIN: begin
          pending <= pending | bus.notify;
          if (infl && infl_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = ~empty;
  assign {bus.out_last, bus.out_col, bus.out_data} = dout;
  assign bus.busy      = pending | (state != IDLE) | ~empty;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_coef_reader.sv
// Directed and randomized checks of coef_reader against a column-stream scoreboard.
module tb_coef_reader;
  localparam int CW   = 16;
  localparam int COLS = 8;
  localparam int DW   = 8*CW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          hs = 0;
  int          pcnt = 0;
  int          mode = 1;
  int          h0;
  logic [15:0] seed = 16'd0;
  logic [3:0]  pat = 4'b1001;

  int          exp_col = 0;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [2:0]  prev_col = 3'd0;

  coef_reader_if #(.CW(CW)) bus ();
  coef_reader #(.COLS(COLS), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Coefficient page: column c lane k holds seed + c*16 + k.
  always_comb begin
    for (int k = 0; k < 8; k++)
      bus.rd_data[CW*k +: CW] = seed + 16'({bus.rd_addr, 4'h0}) + 16'(k);
  end

  function automatic logic [DW-1:0] col_data(input int c, input logic [15:0] s);
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) d[CW*k +: CW] = s + 16'(c*16 + k);
    return d;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake must carry the next column in block order.
  always @(negedge clk) begin
    if (rst) begin
      exp_col    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", DW'(bus.out_valid), DW'(1));
        check("stall_data", bus.out_data, prev_data);
        check("stall_col", DW'(bus.out_col), DW'(prev_col));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("hs_col", DW'(bus.out_col), DW'(exp_col));
        check("hs_data", bus.out_data, col_data(exp_col, seed));
        check("hs_last", DW'(bus.out_last), DW'(exp_col == COLS-1));
        exp_col = (exp_col + 1) % COLS;
        hs++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_col   = bus.out_col;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pcnt++;
    case (mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      2:       bus.out_ready = pat[pcnt[1:0]];
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.notify = 1'b1;
    tick();
    bus.notify = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      sample();
      if (!bus.busy) break;
    end
    check("idle_reached", DW'(bus.busy), DW'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.notify    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    sample();
    check("rst_valid", DW'(bus.out_valid), DW'(0));
    check("rst_busy", DW'(bus.busy), DW'(0));
    check("rst_ovf", DW'(bus.ovf), DW'(0));
    check("rst_addr", DW'(bus.rd_addr), DW'(0));
    check("rst_data", bus.out_data, DW'(0));
    check("rst_col", DW'(bus.out_col), DW'(0));
    check("rst_last", DW'(bus.out_last), DW'(0));
    tick();
    rst = 1'b0;
    mode = 1;
    tick();
    tick();

    // Streaming latency and one column per cycle
    seed = 16'd0;
    h0 = hs;
    pulse();
    sample();
    check("lat_c0", DW'(bus.out_valid), DW'(0));
    tick();
    sample();
    check("lat_c1", DW'(bus.out_valid), DW'(0));
    tick();
    sample();
    check("lat_c2_valid", DW'(bus.out_valid), DW'(1));
    check("lat_c2_col", DW'(bus.out_col), DW'(0));
    for (int i = 1; i < COLS; i++) begin
      tick();
      sample();
      check("stream_valid", DW'(bus.out_valid), DW'(1));
      check("stream_col", DW'(bus.out_col), DW'(i));
    end
    wait_idle(20);
    check("stream_count", DW'(hs - h0), DW'(8));
    check("stream_ovf", DW'(bus.ovf), DW'(0));

    // out_ready pattern 1,0,0,1
    mode = 2;
    seed = 16'($urandom);
    h0 = hs;
    pulse();
    wait_idle(100);
    repeat (5) tick();
    check("toggle_count", DW'(hs - h0), DW'(8));
    check("toggle_ovf", DW'(bus.ovf), DW'(0));

    // Random backpressure, separate blocks with random gaps
    mode = 3;
    for (int b = 0; b < 2; b++) begin
      seed = 16'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      h0 = hs;
      pulse();
      wait_idle(200);
      check("rand_count", DW'(hs - h0), DW'(8));
    end

    // Page flip under an active read at column 4
    mode = 1;
    seed = 16'($urandom);
    h0 = hs;
    pulse();
    for (int n = 0; n < 20; n++) begin
      if (bus.rd_addr == 4'd4) break;
      tick();
    end
    check("ovr_addr4", DW'(bus.rd_addr), DW'(4));
    check("ovr_pre", DW'(bus.ovf), DW'(0));
    pulse();
    sample();
    check("ovr_ovf", DW'(bus.ovf), DW'(1));
    wait_idle(100);
    repeat (5) tick();
    check("ovr_count", DW'(hs - h0), DW'(16));
    check("ovr_sticky", DW'(bus.ovf), DW'(1));

    // Reset clears ovf; two notifies three cycles apart
    rst = 1'b1;
    sample();
    check("rst2_ovf", DW'(bus.ovf), DW'(0));
    tick();
    rst = 1'b0;
    tick();
    seed = 16'($urandom);
    h0 = hs;
    pulse();
    tick();
    tick();
    pulse();
    wait_idle(100);
    check("dbl_count", DW'(hs - h0), DW'(16));
    check("dbl_ovf", DW'(bus.ovf), DW'(1));

    // Stalled sink: only two reads, then reset discards buffered columns
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 0;
    tick();
    seed = 16'($urandom);
    h0 = hs;
    pulse();
    repeat (10) tick();
    sample();
    check("stall_addr", DW'(bus.rd_addr), DW'(1));
    check("stall_busy", DW'(bus.busy), DW'(1));
    check("stall_head_valid", DW'(bus.out_valid), DW'(1));
    check("stall_head_col", DW'(bus.out_col), DW'(0));
    check("stall_no_hs", DW'(hs - h0), DW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      sample();
      check("stall_addr_hold", DW'(bus.rd_addr), DW'(1));
    end
    tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", DW'(bus.out_valid), DW'(0));
    check("midrst_busy", DW'(bus.busy), DW'(0));
    check("midrst_addr", DW'(bus.rd_addr), DW'(0));
    tick();
    rst = 1'b0;
    mode = 1;
    tick();
    seed = 16'($urandom);
    h0 = hs;
    pulse();
    wait_idle(50);
    check("post_rst_count", DW'(hs - h0), DW'(8));
    check("post_rst_ovf", DW'(bus.ovf), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
